rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Write-port controller for the 32x32 register file. After reset it sequences a clear of R0..R30 to zero. In normal operation it shares the file's single write port between the core writeback stage and an auxiliary requester (load return / debug), with a starvation guard. Sits directly in front of the register file write port (we/wa/wd); read ports are untouched.

## Interface

- MAX_WAIT, 4: cycles an aux request may be refused before it gets priority (1..15)
- DATA_W, 32: write data width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_we  in  1  core writeback request
- core_wa  in  5  core write address
- core_wd  in  DATA_W  core write data
- core_stall  out  1  core write not accepted this cycle; core holds request
- aux_valid  in  1  aux write request; once high, held with stable wa/wd until accepted
- aux_wa  in  5  aux write address
- aux_wd  in  DATA_W  aux write data
- aux_ready  out  1  aux write accepted when aux_valid & aux_ready
- init_busy  out  1  clear sequence in progress
- rf_we, rf_wa[4:0], rf_wd[DATA_W-1:0]  out  to register file write port

## Operation

- States: INIT, RUN. Reset enters INIT with clr_cnt=0, wait_cnt=0, starve=0.
- INIT: rf_we=1, rf_wa=clr_cnt, rf_wd=0; clr_cnt increments each cycle; after writing address 30 go to RUN. 31 cycles total. init_busy=1, core_stall=1, aux_ready=0; all requests ignored.
- RUN arbitration (combinational from inputs and registered starve):
  - aux_ready = !core_we | starve
  - core_stall = starve & aux_valid
  - aux granted: aux_valid & aux_ready; rf_* = aux request
  - otherwise core_we & !core_stall: rf_* = core request
  - otherwise rf_we=0, rf_wa/rf_wd don't-care (drive 0)
- Address 31: an accepted write to wa=31 (either port) completes its handshake but drives rf_we=0. R31 is never written.
- Starvation: wait_cnt increments (saturating at MAX_WAIT) each cycle aux_valid & !aux_ready; cleared on aux grant or when aux_valid=0. starve = (wait_cnt == MAX_WAIT), registered.
- Only one write per cycle; no buffering; no data modification.

## Timing

- While rst_n=0: rf_we=0 (gated by rst_n), init_busy=1, core_stall=1, aux_ready=0. A reset asserted mid-INIT or mid-RUN aborts immediately; the clear restarts from R0 on release.
- First RUN cycle: rising edge 31 after the first edge with rst_n=1. init_busy falls on that edge.
- Latency zero: an accepted request reaches rf_* in the same cycle and is written at that cycle's closing edge.
- Simultaneous core_we & aux_valid, starve=0: core wins, aux waits. Aux is guaranteed a grant within MAX_WAIT+1 cycles of raising aux_valid.
- On a starve grant the core write stalls exactly one cycle. starve clears on the next edge.
- core_we & aux_valid with the same address: the writes occur in grant order. The later write wins.

## Test plan

- Reset/clear: preload file with 0xFFFFFFFF, release rst_n -> rf_we=1 for 31 cycles with rf_wa=0..30 and rf_wd=0. init_busy drops after cycle 31. R31 is never addressed. All registers read 0.
- Reset mid-clear: pull rst_n low at clr_cnt=12 -> rf_we=0 immediately. After release, the clear restarts at rf_wa=0 and runs a full 31 cycles.
- Core-only: core_we with wa=5, wd=0x12345678 -> core_stall=0, rf_we=1 same cycle, R5=0x12345678 next cycle. A write with wa=31 -> rf_we=0.
- Contention: core_we held high continuously, aux_valid raised with wa=7, wd=0xA5A5A5A5, MAX_WAIT=4 -> aux refused 4 cycles. Grant occurs on the 5th cycle with core_stall=1 in that cycle only. R7=0xA5A5A5A5 and the stalled core write lands the following cycle.
- Idle core: aux_valid with wa=3 while core_we=0 -> aux_ready=1 and the write completes the same cycle. wait_cnt stays 0.
- Same-address race: core and aux both target R9 (0x1 and 0x2) at starve=0 -> core writes 0x1 first, aux writes 0x2 next cycle. Final R9=0x2.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter_if
//  Description : Bus bundle between the write requesters (core writeback and
//                auxiliary port) and the register-file write arbiter, plus the
//                arbiter's register-file write port outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32
);
  // Core writeback request
  logic              core_we;
  logic [4:0]        core_wa;
  logic [DATA_W-1:0] core_wd;
  logic              core_stall;
  // Auxiliary requester (load return / debug)
  logic              aux_valid;
  logic [4:0]        aux_wa;
  logic [DATA_W-1:0] aux_wd;
  logic              aux_ready;
  // Status
  logic              init_busy;
  // Register file write port
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  // Requester / register-file side
  modport master (
    output core_we, core_wa, core_wd, aux_valid, aux_wa, aux_wd,
    input  core_stall, aux_ready, init_busy, rf_we, rf_wa, rf_wd
  );

  // Arbiter side
  modport slave (
    input  core_we, core_wa, core_wd, aux_valid, aux_wa, aux_wd,
    output core_stall, aux_ready, init_busy, rf_we, rf_wa, rf_wd
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Write-port controller for the 32x32 register file. Clears
//                R0..R30 after reset, then shares the single write port
//                between core writeback and an auxiliary requester with a
//                starvation guard. R31 is never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int MAX_WAIT = 4,   // refusals tolerated before aux gets priority (1..15)
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_write_arbiter_if.slave  bus_if
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] C_MAX_WAIT  = 4'(MAX_WAIT);
  localparam logic [4:0] C_LAST_CLR  = 5'd30;
  localparam logic [4:0] C_R31       = 5'd31;

  state_t      state_q;
  logic [4:0]  clr_cnt_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        starve_q;
  logic        init_busy_q;

  logic              arb_aux_ready;
  logic              arb_core_stall;
  logic              arb_aux_grant;
  logic              arb_we;
  logic [4:0]        arb_wa;
  logic [DATA_W-1:0] arb_wd;

  // Arbitration and write-port mux; zero latency from request to rf_* outputs
  always_comb begin
    arb_aux_ready  = 1'b0;
    arb_core_stall = 1'b1;
    arb_aux_grant  = 1'b0;
    arb_we         = 1'b0;
    arb_wa         = '0;
    arb_wd         = '0;
    wait_cnt_d     = '0;
    if (state_q == ST_INIT) begin
      arb_we = 1'b1;
      arb_wa = clr_cnt_q;
    end else begin
      arb_aux_ready  = !bus_if.core_we || starve_q;
      arb_core_stall = starve_q && bus_if.aux_valid;
      arb_aux_grant  = bus_if.aux_valid && arb_aux_ready;
      if (arb_aux_grant) begin
        // Handshake completes even for R31, but the file is never written there
        arb_we = (bus_if.aux_wa != C_R31);
        arb_wa = bus_if.aux_wa;
        arb_wd = bus_if.aux_wd;
      end else if (bus_if.core_we && !arb_core_stall) begin
        arb_we = (bus_if.core_wa != C_R31);
        arb_wa = bus_if.core_wa;
        arb_wd = bus_if.core_wd;
      end
      // Count refusals; any grant or dropped request restarts the count
      if (bus_if.aux_valid && !arb_aux_ready) begin
        wait_cnt_d = (wait_cnt_q == C_MAX_WAIT) ? wait_cnt_q : wait_cnt_q + 4'd1;
      end
    end
  end

  // Clear sequencer, mode FSM and starvation tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      starve_q    <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          wait_cnt_q <= '0;
          starve_q   <= 1'b0;
          if (clr_cnt_q == C_LAST_CLR) begin
            state_q     <= ST_RUN;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 5'd1;
          end
        end
        default: begin
          wait_cnt_q <= wait_cnt_d;
          // Registered so aux wins on the cycle after the MAX_WAIT-th refusal
          starve_q   <= (wait_cnt_d == C_MAX_WAIT);
        end
      endcase
    end
  end

  // Write enable is forced low while reset is held, independent of state
  assign bus_if.rf_we      = arb_we && rst_n;
  assign bus_if.rf_wa      = arb_wa;
  assign bus_if.rf_wd      = arb_wd;
  assign bus_if.aux_ready  = arb_aux_ready;
  assign bus_if.core_stall = arb_core_stall;
  assign bus_if.init_busy  = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Directed self-checking bench for rf_write_arbiter with a
//                behavioural 32x32 register file behind the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int DATA_W   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] rf_mem [0:31];

  rf_write_arbiter_if #(.DATA_W(DATA_W)) bus_if ();

  rf_write_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .DATA_W   (DATA_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Behavioural register file driven by the arbiter's write port
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= 32'hFFFF_FFFF;
    end else if (bus_if.rf_we) begin
      rf_mem[bus_if.rf_wa] <= bus_if.rf_wd;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.core_we   = 1'b0;
    bus_if.core_wa   = '0;
    bus_if.core_wd   = '0;
    bus_if.aux_valid = 1'b0;
    bus_if.aux_wa    = '0;
    bus_if.aux_wd    = '0;
  endtask

  // Checks `n` clear cycles starting at address `start`; caller sits just after a negedge
  task automatic clear_run(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      #1;
      chk1 ("clr_we",   bus_if.rf_we, 1'b1);
      chk32("clr_wa",   32'(bus_if.rf_wa), 32'(i));
      chk32("clr_wd",   bus_if.rf_wd, 32'h0);
      chk1 ("clr_busy", bus_if.init_busy, 1'b1);
      chk1 ("clr_stall", bus_if.core_stall, 1'b1);
      chk1 ("clr_aready", bus_if.aux_ready, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    drive_idle();
    preload = 1'b1;
    // ---- Reset state ----
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_we",     bus_if.rf_we, 1'b0);
    chk1("rst_busy",   bus_if.init_busy, 1'b1);
    chk1("rst_stall",  bus_if.core_stall, 1'b1);
    chk1("rst_aready", bus_if.aux_ready, 1'b0);

    // ---- Full clear; requests during INIT are ignored ----
    @(negedge clk);
    preload = 1'b0;
    rst_n   = 1'b1;
    bus_if.core_we   = 1'b1;
    bus_if.core_wa   = 5'd2;
    bus_if.core_wd   = 32'hDEAD_BEEF;
    bus_if.aux_valid = 1'b1;
    bus_if.aux_wa    = 5'd4;
    bus_if.aux_wd    = 32'hBEEF_DEAD;
    clear_run(0, 31);
    drive_idle();
    #1;
    chk1("run_busy", bus_if.init_busy, 1'b0);
    chk1("run_idle_we", bus_if.rf_we, 1'b0);
    for (int k = 0; k < 31; k++) chk32($sformatf("clr_R%0d", k), rf_mem[k], 32'h0);
    chk32("R31_untouched", rf_mem[31], 32'hFFFF_FFFF);

    // ---- Core-only write ----
    @(negedge clk);
    bus_if.core_we = 1'b1;
    bus_if.core_wa = 5'd5;
    bus_if.core_wd = 32'h1234_5678;
    #1;
    chk1 ("core_stall", bus_if.core_stall, 1'b0);
    chk1 ("core_we", bus_if.rf_we, 1'b1);
    chk32("core_wa", 32'(bus_if.rf_wa), 32'd5);
    chk32("core_wd", bus_if.rf_wd, 32'h1234_5678);
    @(negedge clk);
    bus_if.core_wa = 5'd31;
    bus_if.core_wd = 32'h0000_0001;
    #1;
    chk32("core_R5", rf_mem[5], 32'h1234_5678);
    chk1 ("core31_stall", bus_if.core_stall, 1'b0);
    chk1 ("core31_we", bus_if.rf_we, 1'b0);

    // ---- Aux with idle core ----
    @(negedge clk);
    drive_idle();
    bus_if.aux_valid = 1'b1;
    bus_if.aux_wa    = 5'd3;
    bus_if.aux_wd    = 32'hCAFE_F00D;
    #1;
    chk1 ("idle_aready", bus_if.aux_ready, 1'b1);
    chk1 ("idle_we", bus_if.rf_we, 1'b1);
    chk32("idle_wa", 32'(bus_if.rf_wa), 32'd3);
    chk32("idle_wd", bus_if.rf_wd, 32'hCAFE_F00D);
    @(negedge clk);
    drive_idle();
    #1;
    chk32("idle_R3", rf_mem[3], 32'hCAFE_F00D);
    chk32("R31_still", rf_mem[31], 32'hFFFF_FFFF);

    // ---- Contention: core held, aux starves for MAX_WAIT cycles ----
    @(negedge clk);
    bus_if.core_we   = 1'b1;
    bus_if.core_wa   = 5'd10;
    bus_if.core_wd   = 32'h1111_1111;
    bus_if.aux_valid = 1'b1;
    bus_if.aux_wa    = 5'd7;
    bus_if.aux_wd    = 32'hA5A5_A5A5;
    for (int k = 0; k < MAX_WAIT; k++) begin
      #1;
      chk1 ("cont_refuse_aready", bus_if.aux_ready, 1'b0);
      chk1 ("cont_refuse_stall", bus_if.core_stall, 1'b0);
      chk32("cont_refuse_wa", 32'(bus_if.rf_wa), 32'd10);
      @(negedge clk);
    end
    #1;
    chk1 ("cont_grant_aready", bus_if.aux_ready, 1'b1);
    chk1 ("cont_grant_stall", bus_if.core_stall, 1'b1);
    chk1 ("cont_grant_we", bus_if.rf_we, 1'b1);
    chk32("cont_grant_wa", 32'(bus_if.rf_wa), 32'd7);
    chk32("cont_grant_wd", bus_if.rf_wd, 32'hA5A5_A5A5);
    @(negedge clk);
    bus_if.aux_valid = 1'b0;
    bus_if.core_wd   = 32'h2222_2222;
    #1;
    chk32("cont_R7", rf_mem[7], 32'hA5A5_A5A5);
    chk1 ("cont_after_stall", bus_if.core_stall, 1'b0);
    chk32("cont_after_wa", 32'(bus_if.rf_wa), 32'd10);
    chk32("cont_after_wd", bus_if.rf_wd, 32'h2222_2222);
    @(negedge clk);
    drive_idle();
    #1;
    chk32("cont_R10", rf_mem[10], 32'h2222_2222);

    // ---- Same-address race on R9 ----
    @(negedge clk);
    bus_if.core_we   = 1'b1;
    bus_if.core_wa   = 5'd9;
    bus_if.core_wd   = 32'h0000_0001;
    bus_if.aux_valid = 1'b1;
    bus_if.aux_wa    = 5'd9;
    bus_if.aux_wd    = 32'h0000_0002;
    #1;
    chk1 ("race_aready0", bus_if.aux_ready, 1'b0);
    chk32("race_wd0", bus_if.rf_wd, 32'h0000_0001);
    @(negedge clk);
    bus_if.core_we = 1'b0;
    #1;
    chk32("race_R9_first", rf_mem[9], 32'h0000_0001);
    chk1 ("race_aready1", bus_if.aux_ready, 1'b1);
    chk32("race_wd1", bus_if.rf_wd, 32'h0000_0002);
    @(negedge clk);
    drive_idle();
    #1;
    chk32("race_R9_final", rf_mem[9], 32'h0000_0002);

    // ---- Aux write to R31 is accepted but suppressed ----
    @(negedge clk);
    bus_if.aux_valid = 1'b1;
    bus_if.aux_wa    = 5'd31;
    bus_if.aux_wd    = 32'h0;
    #1;
    chk1("aux31_aready", bus_if.aux_ready, 1'b1);
    chk1("aux31_we", bus_if.rf_we, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    chk32("aux31_R31", rf_mem[31], 32'hFFFF_FFFF);

    // ---- Reset mid-clear restarts from R0 ----
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("rst2_busy", bus_if.init_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_run(0, 12);
    #1;
    chk32("mid_wa12", 32'(bus_if.rf_wa), 32'd12);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_we", bus_if.rf_we, 1'b0);
    chk1("mid_rst_busy", bus_if.init_busy, 1'b1);
    chk1("mid_rst_aready", bus_if.aux_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_run(0, 31);
    #1;
    chk1("mid_done_busy", bus_if.init_busy, 1'b0);
    chk1("mid_done_we", bus_if.rf_we, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
